// File: rtl/alu_pkg.sv
// Shared ALU definitions: op encodings driven onto the ripple ALU and the
// sequencer state type.
package alu_pkg;

   localparam logic [2:0] ALUOP_AND = 3'b000;
   localparam logic [2:0] ALUOP_OR  = 3'b001;
   localparam logic [2:0] ALUOP_ADD = 3'b010;
   localparam logic [2:0] ALUOP_SUB = 3'b110;
   localparam logic [2:0] ALUOP_SLT = 3'b111;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StFin  = 2'd2
   } seq_state_e;

endpackage

// File: rtl/alu_muldiv_seq_if.sv
// Request/result and ALU-borrow signals of the multiply/divide sequencer.
interface alu_muldiv_seq_if #(
   parameter int unsigned WIDTH = 32
);
   logic             start;
   logic             op_div;
   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;
   logic             busy;
   logic             done;
   logic             div_by_zero;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [2:0]       alu_op;
   logic [WIDTH-1:0] alu_result;
   logic             alu_cout;

   modport master (
      output start, op_div, a_in, b_in, alu_result, alu_cout,
      input  busy, done, div_by_zero, hi, lo, alu_a, alu_b, alu_op
   );

   modport slave (
      input  start, op_div, a_in, b_in, alu_result, alu_cout,
      output busy, done, div_by_zero, hi, lo, alu_a, alu_b, alu_op
   );
endinterface

// File: rtl/alu_ripple.sv
// Ripple ALU (AND/OR/ADD/SUB/SLT) with MSB carry-out; SUB carry-out of 1
// means no borrow.
module alu_ripple #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic [2:0]       op_i,
   output logic [WIDTH-1:0] result_o,
   output logic             cout_o
);
   logic [WIDTH-1:0] b_eff;
   logic [WIDTH:0]   sum;
   logic             ovf;

   always_comb begin
      b_eff  = op_i[2] ? ~b_i : b_i;
      sum    = {1'b0, a_i} + {1'b0, b_eff} + {{WIDTH{1'b0}}, op_i[2]};
      cout_o = sum[WIDTH];
      ovf    = (a_i[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
      result_o = '0;
      unique case (op_i[1:0])
         2'b00:   result_o = a_i & b_i;
         2'b01:   result_o = a_i | b_i;
         2'b10:   result_o = sum[WIDTH-1:0];
         default: result_o = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf};
      endcase
   end
endmodule

// File: rtl/muldiv_step_mux.sv
// One shift-add (MULTU) or restoring shift-subtract (DIVU) step: ALU operand
// selection and the resulting {hi, lo}.
module muldiv_step_mux
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             op_div_i,
   input  logic [WIDTH-1:0] hi_i,
   input  logic [WIDTH-1:0] lo_i,
   input  logic [WIDTH-1:0] opnd_i,
   input  logic [WIDTH-1:0] alu_result_i,
   input  logic             alu_cout_i,
   output logic [WIDTH-1:0] alu_a_o,
   output logic [WIDTH-1:0] alu_b_o,
   output logic [2:0]       alu_op_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);
   logic             r_ext;
   logic [WIDTH-1:0] rs;

   always_comb begin
      r_ext    = hi_i[WIDTH-1];
      rs       = {hi_i[WIDTH-2:0], lo_i[WIDTH-1]};
      alu_a_o  = hi_i;
      alu_b_o  = opnd_i;
      alu_op_o = ALUOP_ADD;
      hi_o     = hi_i;
      lo_o     = lo_i;
      if (op_div_i) begin
         alu_a_o  = rs;
         alu_op_o = ALUOP_SUB;
         // Bit shifted out of hi makes the partial remainder >= 2^WIDTH > divisor.
         if (r_ext || alu_cout_i) begin
            hi_o = alu_result_i;
            lo_o = {lo_i[WIDTH-2:0], 1'b1};
         end else begin
            hi_o = rs;
            lo_o = {lo_i[WIDTH-2:0], 1'b0};
         end
      end else if (lo_i[0]) begin
         {hi_o, lo_o} = {alu_cout_i, alu_result_i, lo_i[WIDTH-1:1]};
      end else begin
         {hi_o, lo_o} = {1'b0, hi_i, lo_i[WIDTH-1:1]};
      end
   end
endmodule

// File: rtl/alu_muldiv_seq.sv
// Unsigned MULTU/DIVU sequencer borrowing the execute-stage ALU, one bit per
// cycle; owns HI/LO.
module alu_muldiv_seq
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 6
) (
   input logic               clk,
   input logic               rst_n,
   alu_muldiv_seq_if.slave   bus
);
   seq_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] opnd_q, opnd_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             div_q, div_d;
   logic             dbz_q, dbz_d;

   logic [WIDTH-1:0] step_a, step_b, step_hi, step_lo;
   logic [2:0]       step_op;

   muldiv_step_mux #(
      .WIDTH (WIDTH)
   ) u_step (
      .op_div_i     (div_q),
      .hi_i         (hi_q),
      .lo_i         (lo_q),
      .opnd_i       (opnd_q),
      .alu_result_i (bus.alu_result),
      .alu_cout_i   (bus.alu_cout),
      .alu_a_o      (step_a),
      .alu_b_o      (step_b),
      .alu_op_o     (step_op),
      .hi_o         (step_hi),
      .lo_o         (step_lo)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         opnd_q  <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         div_q   <= 1'b0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         opnd_q  <= opnd_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         div_q   <= div_d;
         dbz_q   <= dbz_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      opnd_d     = opnd_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      div_d      = div_q;
      dbz_d      = dbz_q;
      bus.alu_a  = '0;
      bus.alu_b  = '0;
      bus.alu_op = ALUOP_AND;
      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               div_d = bus.op_div;
               if (bus.op_div && (bus.b_in == '0)) begin
                  hi_d    = bus.a_in;
                  lo_d    = '1;
                  dbz_d   = 1'b1;
                  state_d = StFin;
               end else begin
                  opnd_d  = bus.op_div ? bus.b_in : bus.a_in;
                  hi_d    = '0;
                  lo_d    = bus.op_div ? bus.a_in : bus.b_in;
                  cnt_d   = '0;
                  dbz_d   = 1'b0;
                  state_d = StRun;
               end
            end
         end
         StRun: begin
            bus.alu_a  = step_a;
            bus.alu_b  = step_b;
            bus.alu_op = step_op;
            hi_d       = step_hi;
            lo_d       = step_lo;
            cnt_d      = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_d = StFin;
            end
         end
         StFin: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   assign bus.busy        = (state_q == StRun);
   assign bus.done        = (state_q == StFin);
   assign bus.div_by_zero = dbz_q;
   assign bus.hi          = hi_q;
   assign bus.lo          = lo_q;
endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Scoreboard bench: issued operations push expected results, a negedge monitor
// checks each done pulse (values, cycle, busy length) for 32- and 8-bit DUTs.
module tb_alu_muldiv_seq;
   import alu_pkg::*;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dbz;
      int          run;
      int          cyc;
   } exp_t;

   logic clk;
   logic rst_n;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   int   t0 = 0;
   int   run32 = 0;
   int   run8 = 0;
   exp_t q32[$];
   exp_t q8[$];

   alu_muldiv_seq_if #(.WIDTH(32)) b32 ();
   alu_muldiv_seq_if #(.WIDTH(8))  b8 ();

   alu_muldiv_seq #(.WIDTH(32), .CNT_W(6)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(b32));
   alu_ripple #(.WIDTH(32)) u_alu32 (
      .a_i(b32.alu_a), .b_i(b32.alu_b), .op_i(b32.alu_op),
      .result_o(b32.alu_result), .cout_o(b32.alu_cout)
   );

   alu_muldiv_seq #(.WIDTH(8), .CNT_W(4)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));
   alu_ripple #(.WIDTH(8)) u_alu8 (
      .a_i(b8.alu_a), .b_i(b8.alu_b), .op_i(b8.alu_op),
      .result_o(b8.alu_result), .cout_o(b8.alu_cout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic issue32(input logic div, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] he, input logic [31:0] le, input logic dz,
                          input bit push);
      exp_t e;
      @(negedge clk);
      b32.start  = 1'b1;
      b32.op_div = div;
      b32.a_in   = a;
      b32.b_in   = b;
      t0 = cyc;
      e.hi = he; e.lo = le; e.dbz = dz;
      e.run = dz ? 0 : 32;
      e.cyc = cyc + (dz ? 1 : 33);
      if (push) q32.push_back(e);
      @(negedge clk);
      b32.start = 1'b0;
      b32.a_in  = $urandom;
      b32.b_in  = $urandom;
   endtask

   task automatic wait_fin(input int lat);
      while (cyc < t0 + lat) @(negedge clk);
   endtask

   // Monitor: pops and compares on every done pulse.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            run32 = 0;
            run8  = 0;
         end else begin
            if (b32.busy) run32++;
            if (b8.busy) run8++;
            if (b32.done) begin
               if (q32.size() == 0) begin
                  chk("done32_unexpected", 1, 0);
               end else begin
                  e = q32.pop_front();
                  chk("hi32", b32.hi, e.hi);
                  chk("lo32", b32.lo, e.lo);
                  chk("dbz32", b32.div_by_zero, e.dbz);
                  chk("run32", run32, e.run);
                  chk("done_cyc32", cyc, e.cyc);
               end
               run32 = 0;
            end
            if (b8.done) begin
               if (q8.size() == 0) begin
                  chk("done8_unexpected", 1, 0);
               end else begin
                  e = q8.pop_front();
                  chk("hi8", b8.hi, e.hi);
                  chk("lo8", b8.lo, e.lo);
                  chk("dbz8", b8.div_by_zero, e.dbz);
                  chk("run8", run8, e.run);
                  chk("done_cyc8", cyc, e.cyc);
               end
               run8 = 0;
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bit   saw;
      exp_t e8;
      rst_n = 1'b0;
      b32.start = 1'b0; b32.op_div = 1'b0; b32.a_in = '0; b32.b_in = '0;
      b8.start  = 1'b0; b8.op_div  = 1'b0; b8.a_in  = '0; b8.b_in  = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_busy", b32.busy, 0);
      chk("rst_done", b32.done, 0);
      chk("rst_hi", b32.hi, 0);
      chk("rst_lo", b32.lo, 0);
      chk("rst_dbz", b32.div_by_zero, 0);
      chk("idle_alu_a", b32.alu_a, 0);
      chk("idle_alu_b", b32.alu_b, 0);
      chk("idle_alu_op", b32.alu_op, 0);

      issue32(1'b0, 32'd7, 32'd6, 32'd0, 32'd42, 1'b0, 1'b1);
      wait_fin(33);
      issue32(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b1);
      wait_fin(33);
      issue32(1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b1);
      chk("run_busy", b32.busy, 1);
      chk("div_alu_op", b32.alu_op, ALUOP_SUB);
      wait_fin(33);
      issue32(1'b1, 32'h8000_0000, 32'd3, 32'd2, 32'h2AAA_AAAA, 1'b0, 1'b1);
      wait_fin(33);
      issue32(1'b1, 32'd55, 32'd0, 32'd55, 32'hFFFF_FFFF, 1'b1, 1'b1);
      wait_fin(1);
      issue32(1'b0, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, 1'b1);
      wait_fin(33);

      // Start pulsed mid-run must be dropped.
      issue32(1'b0, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, 1'b1);
      wait_fin(10);
      chk("mul_alu_op", b32.alu_op, ALUOP_ADD);
      b32.start = 1'b1; b32.op_div = 1'b1; b32.a_in = 32'd100; b32.b_in = 32'd7;
      @(negedge clk);
      b32.start = 1'b0;
      wait_fin(33);
      // Accepted in the IDLE cycle right after FIN.
      issue32(1'b1, 32'd1000, 32'd10, 32'd0, 32'd100, 1'b0, 1'b1);
      wait_fin(33);

      // Reset mid-divide: clears state and suppresses done.
      issue32(1'b1, 32'd100, 32'd7, 32'd0, 32'd0, 1'b0, 1'b0);
      wait_fin(16);
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", b32.busy, 0);
      chk("midrst_hi", b32.hi, 0);
      chk("midrst_lo", b32.lo, 0);
      @(negedge clk);
      rst_n = 1'b1;
      saw = 1'b0;
      while (cyc < t0 + 36) begin
         @(negedge clk);
         if (b32.done) saw = 1'b1;
      end
      chk("midrst_no_done", saw, 0);

      // 8-bit instance: MULTU 255 x 255.
      @(negedge clk);
      b8.start = 1'b1; b8.op_div = 1'b0; b8.a_in = 8'hFF; b8.b_in = 8'hFF;
      t0 = cyc;
      e8.hi = 32'hFE; e8.lo = 32'h01; e8.dbz = 1'b0; e8.run = 8; e8.cyc = cyc + 9;
      q8.push_back(e8);
      @(negedge clk);
      b8.start = 1'b0;
      wait_fin(12);

      chk("q32_empty", q32.size(), 0);
      chk("q8_empty", q8.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/alu_muldiv_seq.md
Name: alu_muldiv_seq

Overview:
- Multi-cycle sequencer that time-shares the existing 32-bit ripple ALU (AND/OR/ADD/SUB/SLT slices, MSB slice with carry-out) to execute unsigned MULTU and DIVU.
- Sits beside the ALU in the execute stage.
- Owns the HI/LO registers and drives the ALU operand and op inputs while busy.
- Multiply uses shift-add; divide uses a restoring shift-subtract. Both take one ALU pass per bit.

Parameters:
- WIDTH, 32, operand width; must equal the ALU width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- op_div  in  1  0 = MULTU, 1 = DIVU; sampled with start.
- a_in  in  WIDTH  multiplicand / dividend.
- b_in  in  WIDTH  multiplier / divisor.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse when hi/lo are valid.
- div_by_zero  out  1  held with the result of a DIVU with b_in = 0; cleared on the next accepted start.
- hi  out  WIDTH  product upper half / remainder.
- lo  out  WIDTH  product lower half / quotient.
- alu_a  out  WIDTH  ALU operand A.
- alu_b  out  WIDTH  ALU operand B.
- alu_op  out  3  {Aluop2, Aluop1, Aluop0}:
  - 010 = ADD
  - 110 = SUB
  - 000 = AND
  - 001 = OR
  - 111 = SLT
- alu_result  in  WIDTH  ALU result.
- alu_cout  in  1  MSB-slice carry-out. For SUB, 1 means no borrow (A >= B unsigned).

Behaviour:
- Clock/reset: single clock domain, clk; rst_n is asynchronous and active-low.
- Reset values (all registers): state = IDLE, busy = 0, done = 0, div_by_zero = 0, hi = 0, lo = 0, counter = 0, operand register = 0.
- ALU outputs when not in RUN: alu_a = 0, alu_b = 0, alu_op = 000.
- States: IDLE, RUN, FIN.
- IDLE, start = 1, op_div = 0:
  - Latch operand register = a_in (multiplicand).
  - hi = 0, lo = b_in, counter = 0, div_by_zero = 0.
  - Next state RUN.
- IDLE, start = 1, op_div = 1, b_in != 0:
  - Latch operand register = b_in (divisor).
  - hi = 0, lo = a_in, counter = 0, div_by_zero = 0.
  - Next state RUN.
- IDLE, start = 1, op_div = 1, b_in == 0:
  - hi = a_in, lo = all ones, div_by_zero = 1.
  - Next state FIN; no RUN cycles.
- RUN, MULTU step:
  - alu_a = hi, alu_b = operand, alu_op = 010.
  - If lo[0] = 1: {hi, lo} <= {alu_cout, alu_result, lo[WIDTH-1:1]}.
  - Else: {hi, lo} <= {1'b0, hi, lo[WIDTH-1:1]}.
- RUN, DIVU step:
  - r_ext = hi[WIDTH-1]; rs = {hi[WIDTH-2:0], lo[WIDTH-1]}.
  - alu_a = rs, alu_b = operand, alu_op = 110.
  - If r_ext or alu_cout: hi <= alu_result, lo <= {lo[WIDTH-2:0], 1}.
  - Else: hi <= rs, lo <= {lo[WIDTH-2:0], 0}.
- RUN counting: counter increments each cycle; after the step with counter == WIDTH-1, go to FIN. RUN lasts exactly WIDTH cycles.
- FIN: done = 1 for exactly this cycle, busy = 0; next state IDLE.
- busy: 1 in RUN only.
- hi/lo: hold their final values until the next accepted start.
- Latency: start accepted at cycle 0.
  - Normal operation: RUN in cycles 1..WIDTH, done at cycle WIDTH+1.
  - Divide-by-zero: done at cycle 1.
- start while in RUN or FIN: ignored and not queued. A new start may be accepted in the IDLE cycle immediately after FIN.
- Operands a_in/b_in: may change freely after the accept cycle.
- rst_n low mid-operation: immediate return to reset values; no done pulse.
- Arithmetic: all unsigned. The product is the full 2*WIDTH bits, with no overflow. alu_overflow (V) is not used by this block.

Decomposition:
- Shared package alu_pkg:
  - ALU op constants ALUOP_AND = 000, ALUOP_OR = 001, ALUOP_ADD = 010, ALUOP_SUB = 110, ALUOP_SLT = 111.
  - State encoding constants ST_IDLE, ST_RUN, ST_FIN.
- One natural sub-module: muldiv_step_mux. It is combinational and selects alu_a/alu_b/alu_op plus the next {hi, lo} from op_div, lo[0], r_ext and alu_cout.
- The FSM and counter stay in the top module.
- The bench instantiates the real ALU and connects it to the alu_* ports.

Test Plan:
- MULTU a = 7, b = 6 -> busy for 32 cycles, done at cycle 33, hi = 0, lo = 42, div_by_zero = 0.
- MULTU a = 0xFFFFFFFF, b = 0xFFFFFFFF -> hi = 0xFFFFFFFE, lo = 0x00000001 (exercises alu_cout capture).
- DIVU a = 100, b = 7 -> lo = 14, hi = 2. DIVU a = 0x80000000, b = 3 -> lo = 0x2AAAAAAA, hi = 2 (exercises the r_ext path).
- DIVU a = 55, b = 0 -> done at cycle 1, hi = 55, lo = 0xFFFFFFFF, div_by_zero = 1. A following MULTU 2×3 clears div_by_zero and gives lo = 6.
- start pulsed at cycle 10 of a MULTU 3×5 -> ignored; result lo = 15. A start in the IDLE cycle after FIN is accepted.
- rst_n asserted at cycle 16 of a DIVU -> hi = lo = 0, busy = 0, and no done at the expected cycle 33. WIDTH = 8 rerun: MULTU 255×255 -> hi = 0xFE, lo = 0x01, done at cycle 9.
